// File: rtl/key_mem_loader.sv
// Keypad-to-RAM program loader: pairs keypad halfwords into 32-bit words,
// writes them to consecutive RAM addresses and holds the CPU in reset while loading.
module key_mem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [15:0] key_data,
    input  logic        load_start,
    input  logic        load_done,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        fpga_enable,
    output logic        cpu_enable,
    output logic        cpu_nrst,
    output logic [10:0] word_count,
    output logic        full
);

    localparam logic [10:0] MaxCount = 11'(MAX_WORDS);

    typedef enum logic [2:0] {
        StIdle,
        StUpper,
        StLower,
        StWrite,
        StFull
    } state_e;

    state_e      state_q, state_d;
    logic        pending_done_q, pending_done_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [10:0] count_q, count_d;
    logic        full_q, full_d;
    logic [10:0] count_inc;

    assign count_inc = count_q + 11'd1;

    always_comb begin
        state_d        = state_q;
        pending_done_d = pending_done_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        count_d        = count_q;
        full_d         = full_q;

        unique case (state_q)
            StIdle: begin
                pending_done_d = 1'b0;
                if (load_start) begin
                    state_d = StUpper;
                    addr_d  = BASE_ADDR;
                    count_d = '0;
                    full_d  = 1'b0;
                end
            end
            // load_done takes priority over a key arriving on the same edge
            StUpper: begin
                if (load_done) begin
                    state_d = StIdle;
                end else if (key_valid) begin
                    wdata_d[31:16] = key_data;
                    state_d        = StLower;
                end
            end
            StLower: begin
                if (load_done) begin
                    state_d = StIdle;
                end else if (key_valid) begin
                    wdata_d[15:0] = key_data;
                    state_d       = StWrite;
                end
            end
            // The write always completes; a done request only redirects the exit
            StWrite: begin
                addr_d  = addr_q + 32'd4;
                count_d = count_inc;
                if (count_inc == MaxCount) begin
                    full_d = 1'b1;
                end
                if (load_done || pending_done_q) begin
                    pending_done_d = 1'b1;
                    state_d        = StIdle;
                end else if (count_inc == MaxCount) begin
                    state_d = StFull;
                end else begin
                    state_d = StUpper;
                end
            end
            StFull: begin
                if (load_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            pending_done_q <= 1'b0;
            addr_q         <= BASE_ADDR;
            wdata_q        <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_done_q <= pending_done_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            count_q        <= count_d;
            full_q         <= full_d;
        end
    end

    // CPU release and RAM hand-back both follow the same state bit, so they switch together
    assign mem_we      = (state_q == StWrite);
    assign fpga_enable = (state_q != StIdle);
    assign cpu_enable  = (state_q == StIdle);
    assign cpu_nrst    = (state_q == StIdle);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign word_count  = count_q;
    assign full        = full_q;

endmodule

// File: tb/tb_key_mem_loader.sv
// Bench for key_mem_loader: directed vector table, corner-case sequences and
// randomized traffic compared against a word-level reference model.
module tb_key_mem_loader;

    localparam logic [31:0] Base = 32'h0000_0000;
    localparam int          MaxW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [15:0] key_data = '0;
    logic        load_start = 1'b0;
    logic        load_done = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        fpga_enable;
    logic        cpu_enable;
    logic        cpu_nrst;
    logic [10:0] word_count;
    logic        full;

    always #5 clk = ~clk;

    key_mem_loader #(
        .BASE_ADDR(Base),
        .MAX_WORDS(MaxW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .load_start (load_start),
        .load_done  (load_done),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .fpga_enable(fpga_enable),
        .cpu_enable (cpu_enable),
        .cpu_nrst   (cpu_nrst),
        .word_count (word_count),
        .full       (full)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: load mode flag, halfwords collected so far, pending write
    bit          m_loading;
    bit          m_have_upper;
    bit          m_write;
    bit          m_full;
    int          m_count;
    logic [31:0] m_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading = 0; m_have_upper = 0; m_write = 0; m_full = 0; m_count = 0; m_wdata = '0;
    endtask

    task automatic model_step(input logic r, ls, ld, kv, input logic [15:0] kd);
        if (r) begin
            model_reset();
        end else if (!m_loading) begin
            if (ls) begin
                m_loading = 1; m_have_upper = 0; m_count = 0; m_full = 0;
            end
        end else if (m_write) begin
            m_write = 0;
            m_count++;
            if (m_count == MaxW) m_full = 1;
            if (ld) m_loading = 0;
        end else if (m_full) begin
            if (ld) m_loading = 0;
        end else if (ld) begin
            m_loading = 0; m_have_upper = 0;
        end else if (kv) begin
            if (!m_have_upper) begin
                m_wdata[31:16] = kd; m_have_upper = 1;
            end else begin
                m_wdata[15:0] = kd; m_have_upper = 0; m_write = 1;
            end
        end
    endtask

    task automatic compare_model();
        check("we", 32'(mem_we), 32'(m_write));
        check("fpga_enable", 32'(fpga_enable), 32'(m_loading));
        check("cpu_enable", 32'(cpu_enable), 32'(!m_loading));
        check("cpu_nrst", 32'(cpu_nrst), 32'(!m_loading));
        check("addr", mem_addr, Base + 32'(4 * m_count));
        check("wdata", mem_wdata, m_wdata);
        check("count", 32'(word_count), 32'(m_count));
        check("full", 32'(full), 32'(m_full));
    endtask

    task automatic drive_edge(input logic r, ls, ld, kv, input logic [15:0] kd);
        @(negedge clk);
        rst = r; load_start = ls; load_done = ld; key_valid = kv; key_data = kd;
        @(posedge clk);
        model_step(r, ls, ld, kv, kd);
        #1;
    endtask

    task automatic step(input logic r, ls, ld, kv, input logic [15:0] kd);
        drive_edge(r, ls, ld, kv, kd);
        compare_model();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, mem_addr, Base);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_count"}, 32'(word_count), 32'd0);
        check({tag, "_full"}, 32'(full), 32'd0);
        check({tag, "_ctrl"}, 32'({fpga_enable, cpu_enable, cpu_nrst}), 32'b011);
    endtask

    typedef struct {
        logic        r, ls, ld, kv;
        logic [15:0] kd;
        logic        we;
        logic [31:0] addr, wdata;
        logic [10:0] cnt;
        logic        fpga, nrst;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // Two-word load, then a partial abort; expected values after each edge
        tbl[0]  = '{1, 0, 0, 0, 16'h0000, 0, 32'h0, 32'h0000_0000, 11'd0, 0, 1};
        tbl[1]  = '{0, 1, 0, 0, 16'h0000, 0, 32'h0, 32'h0000_0000, 11'd0, 1, 0};
        tbl[2]  = '{0, 0, 0, 1, 16'h0013, 0, 32'h0, 32'h0013_0000, 11'd0, 1, 0};
        tbl[3]  = '{0, 0, 0, 1, 16'h0001, 1, 32'h0, 32'h0013_0001, 11'd0, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 16'h0000, 0, 32'h4, 32'h0013_0001, 11'd1, 1, 0};
        tbl[5]  = '{0, 0, 0, 1, 16'h00A0, 0, 32'h4, 32'h00A0_0001, 11'd1, 1, 0};
        tbl[6]  = '{0, 0, 0, 1, 16'h0093, 1, 32'h4, 32'h00A0_0093, 11'd1, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 16'h0000, 0, 32'h8, 32'h00A0_0093, 11'd2, 1, 0};
        tbl[8]  = '{0, 0, 1, 0, 16'h0000, 0, 32'h8, 32'h00A0_0093, 11'd2, 0, 1};
        tbl[9]  = '{0, 1, 0, 0, 16'h0000, 0, 32'h0, 32'h00A0_0093, 11'd0, 1, 0};
        tbl[10] = '{0, 0, 0, 1, 16'hBEEF, 0, 32'h0, 32'hBEEF_0093, 11'd0, 1, 0};
        tbl[11] = '{0, 0, 1, 0, 16'h0000, 0, 32'h0, 32'hBEEF_0093, 11'd0, 0, 1};
        tbl[12] = '{0, 0, 0, 0, 16'h0000, 0, 32'h0, 32'hBEEF_0093, 11'd0, 0, 1};

        model_reset();
        for (int i = 0; i < 13; i++) begin
            drive_edge(tbl[i].r, tbl[i].ls, tbl[i].ld, tbl[i].kv, tbl[i].kd);
            check($sformatf("vec%0d_we", i), 32'(mem_we), 32'(tbl[i].we));
            check($sformatf("vec%0d_addr", i), mem_addr, tbl[i].addr);
            check($sformatf("vec%0d_wdata", i), mem_wdata, tbl[i].wdata);
            check($sformatf("vec%0d_count", i), 32'(word_count), 32'(tbl[i].cnt));
            check($sformatf("vec%0d_fpga", i), 32'(fpga_enable), 32'(tbl[i].fpga));
            check($sformatf("vec%0d_nrst", i), 32'(cpu_nrst), 32'(tbl[i].nrst));
        end

        // Key and done together in the lower phase: done wins, no write
        step(1, 0, 0, 0, 16'h0);
        step(0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 1, 16'h1111);
        step(0, 0, 1, 1, 16'h2222);
        check("lower_done_fpga", 32'(fpga_enable), 32'd0);
        check("lower_done_we", 32'(mem_we), 32'd0);
        step(0, 0, 0, 0, 16'h0);
        check("lower_done_we_next", 32'(mem_we), 32'd0);
        check("lower_done_count", 32'(word_count), 32'd0);

        // Done during the write cycle: write completes, then idle
        step(0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 1, 16'h3333);
        step(0, 0, 0, 1, 16'h4444);
        check("write_done_we", 32'(mem_we), 32'd1);
        check("write_done_data", mem_wdata, 32'h3333_4444);
        step(0, 0, 1, 0, 16'h0);
        check("write_done_fpga", 32'(fpga_enable), 32'd0);
        check("write_done_count", 32'(word_count), 32'd1);
        check("write_done_addr", mem_addr, 32'h4);
        step(0, 0, 0, 0, 16'h0);
        check("write_done_we_next", 32'(mem_we), 32'd0);

        // Fill the window
        step(0, 1, 0, 0, 16'h0);
        for (int w = 0; w < MaxW; w++) begin
            step(0, 0, 0, 1, 16'(w + 16'hA0));
            step(0, 0, 0, 1, 16'(w + 16'h50));
            check($sformatf("fill%0d_we", w), 32'(mem_we), 32'd1);
            check($sformatf("fill%0d_addr", w), mem_addr, 32'(4 * w));
            step(0, 0, 0, 0, 16'h0);
        end
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(word_count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, 16'hFFFF);
            check($sformatf("full_key%0d_we", k), 32'(mem_we), 32'd0);
        end
        step(0, 0, 1, 0, 16'h0);
        check("full_done_fpga", 32'(fpga_enable), 32'd0);
        check("full_done_flag_held", 32'(full), 32'd1);

        // Reset in the write cycle and in the lower phase
        step(0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 1, 16'h1234);
        step(0, 0, 0, 1, 16'h5678);
        step(1, 0, 0, 0, 16'h0);
        check_reset_values("rst_write");
        step(0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 1, 16'h9ABC);
        step(1, 0, 0, 1, 16'hDEF0);
        check_reset_values("rst_lower");
        step(0, 0, 0, 1, 16'h1);
        step(0, 0, 1, 1, 16'h2);
        step(0, 0, 0, 1, 16'h3);
        check("idle_keys_we", 32'(mem_we), 32'd0);
        check("idle_keys_fpga", 32'(fpga_enable), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(15) == 0),
                 ($urandom_range(1) == 0), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
